// File: rtl/sync_channel_arbiter.sv
//------------------------------------------------------------------------------
// sync_channel_arbiter
//
// Sender-side controller for one NoC synchronizer channel.
//
// NUM_SRC local flit sources share one toggle-request / level-acknowledge
// crossing. Sources are picked round-robin. For each accepted flit the
// controller:
//   1. registers the flit data,
//   2. toggles req,
//   3. waits until the far-end receiver mirrors req on ack.
// Only then can the next flit start. The receiver's chnl_stop backpressure is
// honoured while idle.
//
// Optional feature (compile-time macro SYNC_ARB_WORMHOLE_EN):
//   Wormhole packet lock. Once a source's non-tail flit is accepted, only that
//   source stays eligible until its tail flit is accepted. Without the macro,
//   src_tail is ignored.
//
// Parameters:
//   DATA_WIDTH  flit width, must match the receiving synchronizer (34)
//   NUM_SRC     number of requesters, 2..8 (4)
//
// Ports:
//   clock      in   single clock, rising edge
//   reset      in   synchronous, active-low reset
//   src_valid  in   [NUM_SRC]            per-source flit valid
//   src_data   in   [NUM_SRC*DATA_WIDTH] source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_tail   in   [NUM_SRC]            flit is last of its packet
//   src_ready  out  [NUM_SRC]            combinational accept strobe
//   req        out                       registered toggle request
//   ack        in                        receiver acknowledge (asynchronous)
//   data_out   out  [DATA_WIDTH]         registered channel data
//   chnl_stop  in                        receiver stop (asynchronous)
//   grant      out  [NUM_SRC]            one-hot owner of flit in flight, 0 idle
//   busy       out                       high while a flit is in flight
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_channel_arbiter #(
   parameter int DATA_WIDTH = 34,
   parameter int NUM_SRC    = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   input  logic [NUM_SRC-1:0]            src_tail,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic                          req,
   input  logic                          ack,
   output logic [DATA_WIDTH-1:0]         data_out,
   input  logic                          chnl_stop,
   output logic [NUM_SRC-1:0]            grant,
   output logic                          busy
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LAUNCH   = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_nextState;

   logic                  r_ackMeta;
   logic                  r_ackSync;
   logic                  r_stopMeta;
   logic                  r_stopSync;

   logic                  r_req;
   logic [DATA_WIDTH-1:0] r_dataOut;
   logic [NUM_SRC-1:0]    r_grant;
   logic [IDX_W-1:0]      r_winner;
   logic [IDX_W-1:0]      r_rrPtr;

   logic [NUM_SRC-1:0]    w_eligible;
   logic                  w_found;
   logic [IDX_W-1:0]      w_winIdx;
   logic [NUM_SRC-1:0]    w_winOneHot;
   logic [DATA_WIDTH-1:0] w_winData;
   logic                  w_canAccept;
   logic                  w_accept;
   logic                  w_ackMatch;
   logic                  w_ptrAdvance;
   logic [IDX_W-1:0]      w_nextPtr;
   int                    w_scanIdx;

`ifdef SYNC_ARB_WORMHOLE_EN
   logic                  r_locked;
   logic [IDX_W-1:0]      r_lockSrc;

   // While a packet is open, only the owning source may compete; everyone
   // else is masked out even though they may be presenting valid flits.
   always_comb begin
      w_eligible = src_valid;
      if (r_locked) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            w_eligible[k] = src_valid[k] && (r_lockSrc == IDX_W'(k));
         end
      end
   end

   // The pointer only moves past a source once its packet is finished, so a
   // multi-flit packet does not hand the priority away halfway through.
   assign w_ptrAdvance = !r_locked;

   // Packet lock. It is updated on every acceptance: a non-tail flit opens or
   // keeps the lock on its source, and a tail flit releases it. Stop does not
   // touch it, so a packet resumes with the same owner after backpressure.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_locked  <= 1'b0;
         r_lockSrc <= '0;
      end else if (w_accept) begin
         r_locked  <= !src_tail[w_winIdx];
         r_lockSrc <= w_winIdx;
      end
   end
`else
   logic w_unusedTail;

   // Every flit is arbitrated on its own; tail markers carry no meaning here.
   assign w_eligible   = src_valid;
   assign w_ptrAdvance = 1'b1;
   assign w_unusedTail = ^src_tail;
`endif

   // Round-robin scan. It starts at the pointer, wraps past the highest
   // source, and takes the first eligible source found.
   always_comb begin
      w_found   = 1'b0;
      w_winIdx  = '0;
      w_scanIdx = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_scanIdx = (int'(r_rrPtr) + k) % NUM_SRC;
         if (!w_found && w_eligible[w_scanIdx]) begin
            w_found  = 1'b1;
            w_winIdx = IDX_W'(w_scanIdx);
         end
      end
   end

   // Decode the winner into a one-hot vector and select its data slice.
   always_comb begin
      w_winOneHot = '0;
      w_winData   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (w_winIdx == IDX_W'(k)) begin
            w_winOneHot[k] = 1'b1;
            w_winData      = src_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // An acceptance needs all of the following:
   //   - reset released,
   //   - the controller idle,
   //   - no synchronized stop,
   //   - an eligible winner.
   // Gating on reset keeps src_ready low for the whole reset assertion.
   assign w_canAccept = reset && !r_stopSync && w_found && (r_state == ST_IDLE);

   // Next-state logic for the single-flit-in-flight handshake.
   //   IDLE     -> LAUNCH    on acceptance
   //   LAUNCH   -> WAIT_ACK  while req toggles
   //   WAIT_ACK -> IDLE      once the synchronized ack catches up with req
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_ackMatch  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_canAccept) begin
               w_accept    = 1'b1;
               w_nextState = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            w_nextState = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (r_ackSync == r_req) begin
               w_ackMatch  = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Next pointer: one past the source that just finished, wrapping to zero.
   assign w_nextPtr = (r_winner == IDX_W'(NUM_SRC - 1)) ? '0 : (r_winner + IDX_W'(1));

   // Main sequential block. It holds:
   //   - the two-flop synchronizers for ack and stop,
   //   - the state register,
   //   - the data/grant capture on acceptance,
   //   - the req toggle in LAUNCH,
   //   - the release of grant and pointer update when the handshake closes.
   // data_out is left untouched after acceptance, so it stays stable across
   // the req toggle until the next flit replaces it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_ackMeta  <= 1'b0;
         r_ackSync  <= 1'b0;
         r_stopMeta <= 1'b0;
         r_stopSync <= 1'b0;
         r_state    <= ST_IDLE;
         r_req      <= 1'b0;
         r_dataOut  <= '0;
         r_grant    <= '0;
         r_winner   <= '0;
         r_rrPtr    <= '0;
      end else begin
         r_ackMeta  <= ack;
         r_ackSync  <= r_ackMeta;
         r_stopMeta <= chnl_stop;
         r_stopSync <= r_stopMeta;
         r_state    <= w_nextState;
         if (w_accept) begin
            r_dataOut <= w_winData;
            r_grant   <= w_winOneHot;
            r_winner  <= w_winIdx;
         end
         if (r_state == ST_LAUNCH) begin
            r_req <= ~r_req;
         end
         if (w_ackMatch) begin
            r_grant <= '0;
            if (w_ptrAdvance) begin
               r_rrPtr <= w_nextPtr;
            end
         end
      end
   end

   // src_ready is a pure decode of the current acceptance decision.
   assign src_ready = w_accept ? w_winOneHot : '0;
   assign req       = r_req;
   assign data_out  = r_dataOut;
   assign grant     = r_grant;
   assign busy      = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_ACK);

endmodule

// File: tb/tb_sync_channel_arbiter.sv
//------------------------------------------------------------------------------
// tb_sync_channel_arbiter
//
// Directed bench for sync_channel_arbiter (DATA_WIDTH=34, NUM_SRC=4).
//
// A small receiver model echoes req onto ack a few cycles after each toggle.
// Inputs change 1ns after a rising edge; outputs are sampled on falling edges.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sync_channel_arbiter;

   localparam int DW = 34;
   localparam int NS = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [NS-1:0]    src_valid = '0;
   logic [NS*DW-1:0] src_data = '0;
   logic [NS-1:0]    src_tail = '1;
   logic [NS-1:0]    src_ready;
   logic             req;
   logic             ack = 1'b0;
   logic [DW-1:0]    data_out;
   logic             chnl_stop = 1'b0;
   logic [NS-1:0]    grant;
   logic             busy;

   int vectorCount = 0;
   int missCount   = 0;
   int ackDelay    = 0;

   sync_channel_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
      .clock     (clock),
      .reset     (reset),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_tail  (src_tail),
      .src_ready (src_ready),
      .req       (req),
      .ack       (ack),
      .data_out  (data_out),
      .chnl_stop (chnl_stop),
      .grant     (grant),
      .busy      (busy)
   );

   // 100 MHz clock.
   always #5 clock = ~clock;

   // Receiver model. It is reset together with the sender and mirrors req onto
   // ack on the fourth falling edge after it sees them differ.
   always @(negedge clock) begin
      if (!reset) begin
         ack      = 1'b0;
         ackDelay = 0;
      end else if (req != ack) begin
         ackDelay++;
         if (ackDelay >= 4) begin
            ack      = req;
            ackDelay = 0;
         end
      end
   end

   // Hard stop in case the whole run wedges somewhere unexpected.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NS-1:0] valid, input logic [NS-1:0] tail);
      src_valid = valid;
      src_tail  = tail;
   endtask

   task automatic setData(input int src, input logic [DW-1:0] value);
      src_data[src*DW +: DW] = value;
   endtask

   task automatic nextEdge();
      @(posedge clock);
      #1;
   endtask

   // Wait on falling edges until some source sees valid & ready; the flit
   // transfers on the following rising edge.
   task automatic waitAnyAccept(output int src, output bit ok);
      ok  = 1'b0;
      src = -1;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clock);
         if ((src_valid & src_ready) != '0) begin
            ok = 1'b1;
            for (int k = 0; k < NS; k++) begin
               if (src_ready[k]) src = k;
            end
         end
      end
   endtask

   task automatic waitIdle(input string tag);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clock);
         if (!busy && grant == '0) ok = 1'b1;
      end
      checkOutput(tag, 64'(ok), 64'd1);
   endtask

   initial begin
      int  w;
      bit  ok;
      int  lat;
      int  cnt0;
      int  cnt1;
      int  expOrder[4];
      logic [NS-1:0] seenReady;

      // Reset held with every source valid: nothing may leak out.
      applyStimulus(4'b1111, 4'b1111);
      for (int i = 0; i < NS; i++) setData(i, DW'(64'h3_0000_0000 + 64'(i)));
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_req", 64'(req), 64'd0);
      checkOutput("rst_data", 64'(data_out), 64'd0);
      checkOutput("rst_grant", 64'(grant), 64'd0);
      checkOutput("rst_ready", 64'(src_ready), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);

      // Single source 2, first flit.
      nextEdge();
      reset = 1'b1;
      applyStimulus(4'b0100, 4'b1111);
      setData(2, DW'(34'h2A5));
      waitAnyAccept(w, ok);
      checkOutput("single_acc_ok", 64'(ok), 64'd1);
      checkOutput("single_src", 64'(w), 64'd2);
      checkOutput("single_ready", 64'(src_ready), 64'h4);
      nextEdge();
      applyStimulus(4'b0000, 4'b1111);
      @(negedge clock);
      checkOutput("single_data", 64'(data_out), 64'h2A5);
      checkOutput("single_grant", 64'(grant), 64'h4);
      checkOutput("single_busy", 64'(busy), 64'd1);
      checkOutput("single_req_pre", 64'(req), 64'd0);
      @(negedge clock);
      checkOutput("single_req_tgl", 64'(req), 64'd1);
      waitIdle("single_idle1");

      // Single source 2, second flit: req returns to 0.
      nextEdge();
      setData(2, DW'(34'h155));
      applyStimulus(4'b0100, 4'b1111);
      waitAnyAccept(w, ok);
      checkOutput("single2_src", 64'(w), 64'd2);
      nextEdge();
      applyStimulus(4'b0000, 4'b1111);
      @(negedge clock);
      checkOutput("single2_data", 64'(data_out), 64'h155);
      @(negedge clock);
      checkOutput("single2_req", 64'(req), 64'd0);
      waitIdle("single_idle2");

      // Fresh reset so the pointer starts at 0, then all four sources request.
      nextEdge();
      reset = 1'b0;
      nextEdge();
      nextEdge();
      reset = 1'b1;
      applyStimulus(4'b1111, 4'b1111);
      for (int i = 0; i < NS; i++) setData(i, DW'(34'h100 + 34'(i)));
      for (int i = 0; i < 5; i++) begin
         waitAnyAccept(w, ok);
         checkOutput($sformatf("fair_order%0d", i), 64'(w), 64'(i % NS));
         nextEdge();
         if (i == 4) applyStimulus(4'b0000, 4'b1111);
         @(negedge clock);
         checkOutput($sformatf("fair_data%0d", i), 64'(data_out), 64'h100 + 64'(i % NS));
      end
      waitIdle("fair_idle");

      // Stop raised while a flit is waiting for its ack.
      nextEdge();
      setData(0, DW'(34'h3C));
      applyStimulus(4'b0001, 4'b1111);
      waitAnyAccept(w, ok);
      checkOutput("stop_src", 64'(w), 64'd0);
      nextEdge();
      setData(0, DW'(34'h3D));
      nextEdge();
      chnl_stop = 1'b1;
      waitIdle("stop_drain");
      checkOutput("stop_req", 64'(req), 64'd0);
      checkOutput("stop_ack", 64'(ack), 64'd0);
      seenReady = '0;
      repeat (10) begin
         @(negedge clock);
         seenReady = seenReady | src_ready;
      end
      checkOutput("stop_hold", 64'(seenReady), 64'd0);
      nextEdge();
      chnl_stop = 1'b0;
      lat = 0;
      ok  = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clock);
         lat++;
         if (src_ready[0]) ok = 1'b1;
      end
      checkOutput("stop_resume_ok", 64'(ok), 64'd1);
      checkOutput("stop_resume_lat", 64'(lat), 64'd3);
      nextEdge();
      applyStimulus(4'b0000, 4'b1111);
      @(negedge clock);
      checkOutput("stop_resume_data", 64'(data_out), 64'h3D);
      waitIdle("stop_idle");

      // Source 1 sends a 3-flit packet while source 0 has 2 single flits.
      // The pointer is 1 here.
`ifdef SYNC_ARB_WORMHOLE_EN
      expOrder = '{1, 1, 1, 0};
`else
      expOrder = '{1, 0, 1, 0};
`endif
      nextEdge();
      cnt0 = 2;
      cnt1 = 3;
      setData(0, DW'(34'h200));
      setData(1, DW'(34'h210));
      applyStimulus({2'b00, (cnt1 > 0), (cnt0 > 0)}, {2'b11, (cnt1 == 1), 1'b1});
      for (int i = 0; i < 4; i++) begin
         waitAnyAccept(w, ok);
         checkOutput($sformatf("pkt_order%0d", i), 64'(w), 64'(expOrder[i]));
         nextEdge();
         if (w == 0) cnt0--;
         else if (w == 1) cnt1--;
         setData(0, DW'(34'h200 + 34'(2 - cnt0)));
         setData(1, DW'(34'h210 + 34'(3 - cnt1)));
         applyStimulus({2'b00, (cnt1 > 0), (cnt0 > 0)}, {2'b11, (cnt1 == 1), 1'b1});
      end
      applyStimulus(4'b0000, 4'b1111);
      waitIdle("pkt_idle");

      // Reset in the middle of a transfer, with sources 0 and 1 both pending.
      nextEdge();
      setData(0, DW'(34'h0AA));
      setData(1, DW'(34'h3FF));
      applyStimulus(4'b0011, 4'b1111);
      waitAnyAccept(w, ok);
      checkOutput("midrst_first", 64'(w), 64'd1);
      nextEdge();
      nextEdge();
      checkOutput("midrst_busy_pre", 64'(busy), 64'd1);
      reset = 1'b0;
      nextEdge();
      @(negedge clock);
      checkOutput("midrst_req", 64'(req), 64'd0);
      checkOutput("midrst_grant", 64'(grant), 64'd0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_data", 64'(data_out), 64'd0);
      checkOutput("midrst_ready", 64'(src_ready), 64'd0);
      nextEdge();
      reset = 1'b1;
      waitAnyAccept(w, ok);
      checkOutput("midrst_after", 64'(w), 64'd0);
      nextEdge();
      applyStimulus(4'b0000, 4'b1111);
      @(negedge clock);
      checkOutput("midrst_after_data", 64'(data_out), 64'h0AA);
      waitIdle("midrst_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
